// File: rtl/occupancy_pkg.sv
// -----------------------------------------------------------------------------
// occupancy_pkg
// Shared types and helpers for the log-odds occupancy grid engine.
//   cell_t   : signed log-odds cell value
//   state_t  : top-level control state (CLEAR sweep / IDLE service)
//   sat_add  : add a signed delta to a cell and clamp to [min, max]
// -----------------------------------------------------------------------------
package occupancy_pkg;

  localparam int DEF_CELL_BITS = 8;

  typedef logic signed [DEF_CELL_BITS-1:0] cell_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // The sum is formed one bit wider than a cell so that the overflow is
  // visible before clamping. Bounds are symmetric, so the most-negative
  // cell code can never be produced.
  function automatic cell_t sat_add(input cell_t old, input int delta,
                                    input int min, input int max);
    logic signed [DEF_CELL_BITS:0] sum;
    logic signed [DEF_CELL_BITS:0] lo;
    logic signed [DEF_CELL_BITS:0] hi;
    sum = $signed({old[DEF_CELL_BITS-1], old}) + $signed(delta[DEF_CELL_BITS:0]);
    lo  = $signed(min[DEF_CELL_BITS:0]);
    hi  = $signed(max[DEF_CELL_BITS:0]);
    if (sum > hi) begin
      return hi[DEF_CELL_BITS-1:0];
    end else if (sum < lo) begin
      return lo[DEF_CELL_BITS-1:0];
    end
    return sum[DEF_CELL_BITS-1:0];
  endfunction

endpackage

// File: rtl/grid_ram.sv
// -----------------------------------------------------------------------------
// grid_ram
// Simple-dual-port RAM: one write port, one read port, registered read.
// A read of the address being written in the same cycle returns the old
// contents. No reset on the array; contents are initialised by the owner.
// Ports:
//   clock : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (sampled every cycle)
//   rdata : read data, one cycle after raddr
// -----------------------------------------------------------------------------
module grid_ram #(
  parameter int ADDR_BITS = 15,
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/occupancy_grid_updater.sv
// -----------------------------------------------------------------------------
// occupancy_grid_updater
// Log-odds occupancy grid: saturating hit/miss updates at one per cycle,
// a hardware clear sweep after reset or on request, and a single-cycle
// latency query port for the scan matcher.
// Ports:
//   clock          : clock, rising edge
//   reset_n        : synchronous active-low reset (forces a fresh clear sweep)
//   clear_req      : pulse; starts a clear sweep when IDLE
//   busy           : clear sweep in progress
//   clear_done     : pulse on the last clear write
//   upd_valid/ready, upd_x, upd_y, upd_free : update request handshake
//   qry_valid/ready, qry_x, qry_y           : query request handshake
//   qry_data_valid, qry_data                : query response (held until next)
// -----------------------------------------------------------------------------
module occupancy_grid_updater
  import occupancy_pkg::*;
#(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int CELL_BITS = DEF_CELL_BITS,
  parameter int HIT_INC   = 1,
  parameter int MISS_DEC  = 1,
  parameter int CELL_MAX  = 2**(CELL_BITS-1) - 1,
  parameter int CELL_MIN  = -(2**(CELL_BITS-1) - 1)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear_req,
  output logic                        busy,
  output logic                        clear_done,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [X_BITS-1:0]           upd_x,
  input  logic [Y_BITS-1:0]           upd_y,
  input  logic                        upd_free,
  input  logic                        qry_valid,
  output logic                        qry_ready,
  input  logic [X_BITS-1:0]           qry_x,
  input  logic [Y_BITS-1:0]           qry_y,
  output logic                        qry_data_valid,
  output logic signed [CELL_BITS-1:0] qry_data
);

  localparam int ADDR_BITS = X_BITS + Y_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  // control state
  state_t                 state_reg;
  state_t                 state_next;
  logic [ADDR_BITS-1:0]   cnt_reg;
  logic [ADDR_BITS-1:0]   cnt_next;

  // handshakes
  logic                   upd_fire;
  logic                   qry_fire;
  logic [ADDR_BITS-1:0]   upd_addr;
  logic [ADDR_BITS-1:0]   qry_addr;

  // update stage S1
  logic                   s1_valid_reg;
  logic [ADDR_BITS-1:0]   s1_addr_reg;
  logic                   s1_free_reg;
  logic                   s1_fwd_reg;
  cell_t                  s1_fwd_data_reg;
  cell_t                  s1_old;
  cell_t                  s1_new;

  // query response stage
  logic                   q1_valid_reg;
  logic                   q1_fwd_reg;
  cell_t                  q1_fwd_data_reg;
  cell_t                  q1_value;
  cell_t                  qry_hold_reg;

  // RAM ports
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_waddr;
  cell_t                  ram_wdata;
  logic [ADDR_BITS-1:0]   ram_raddr;
  cell_t                  ram_rdata;

  assign upd_addr = {upd_y, upd_x};
  assign qry_addr = {qry_y, qry_x};
  assign upd_fire = upd_valid & upd_ready;
  assign qry_fire = qry_valid & qry_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        // single pass: leave on the last address instead of wrapping
        if (cnt_reg == LAST_ADDR) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Everything is forced to its reset value combinationally
  // while reset_n is low so no stale pipeline state leaks out.
  // upd_ready drops on clear_req so no new update can still be in S1 once the
  // sweep has started; an update already in S1 writes during this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy           = 1'b1;
    clear_done     = 1'b0;
    upd_ready      = 1'b0;
    qry_ready      = 1'b0;
    qry_data_valid = 1'b0;
    qry_data       = '0;
    if (reset_n) begin
      busy           = (state_reg == CLEAR);
      clear_done     = (state_reg == CLEAR) && (cnt_reg == LAST_ADDR);
      upd_ready      = (state_reg == IDLE) && !clear_req;
      qry_ready      = (state_reg == IDLE) && !upd_valid;
      qry_data_valid = q1_valid_reg;
      qry_data       = q1_valid_reg ? q1_value : qry_hold_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Update datapath
  // ---------------------------------------------------------------------------
  assign s1_old = s1_fwd_reg ? s1_fwd_data_reg : ram_rdata;
  assign s1_new = sat_add(s1_old, s1_free_reg ? -MISS_DEC : HIT_INC,
                          CELL_MIN, CELL_MAX);

  assign q1_value = q1_fwd_reg ? q1_fwd_data_reg : ram_rdata;

  // Pipeline valids and the held query result are reset; everything else is
  // pure datapath qualified by those valids.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      q1_valid_reg <= 1'b0;
      qry_hold_reg <= '0;
    end else begin
      s1_valid_reg <= upd_fire;
      q1_valid_reg <= qry_fire;
      if (q1_valid_reg) begin
        qry_hold_reg <= q1_value;
      end
    end
  end

  // The RAM read issued this cycle misses the write S1 performs this cycle
  // (read-old behaviour), so capture that write value for the next stage
  // whenever the addresses match.
  always_ff @(posedge clock) begin
    if (upd_fire) begin
      s1_addr_reg <= upd_addr;
      s1_free_reg <= upd_free;
    end
    s1_fwd_reg      <= s1_valid_reg && (s1_addr_reg == upd_addr);
    s1_fwd_data_reg <= s1_new;
    q1_fwd_reg      <= s1_valid_reg && (s1_addr_reg == qry_addr);
    q1_fwd_data_reg <= s1_new;
  end

  // ---------------------------------------------------------------------------
  // RAM port muxing. The sweep owns the write port in CLEAR; S1 never
  // overlaps with CLEAR because upd_ready is low on the clear_req cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr_reg;
    ram_wdata = s1_new;
    if (state_reg == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_reg;
      ram_wdata = '0;
    end else if (s1_valid_reg) begin
      ram_we = 1'b1;
    end
  end

  // Updates have priority on the single read port.
  assign ram_raddr = upd_valid ? upd_addr : qry_addr;

  grid_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DEF_CELL_BITS)
  ) u_grid_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/occupancy_grid_updater.md
Name: occupancy_grid_updater

Overview:
Parametrised log-odds occupancy grid engine for the Hector SLAM map.
- Holds a 2^Y_BITS x 2^X_BITS grid of signed cells in an internal simple-dual-port RAM.
- Applies saturating hit/miss updates with a valid/ready handshake, sustaining one update per cycle.
- Runs a hardware clear sweep after reset or on request, and serves a one-cycle-latency query port for the scan matcher.

Parameters:
X_BITS, 8, x index width
Y_BITS, 7, y index width
CELL_BITS, 8, signed two's-complement cell width
HIT_INC, 1, added to a cell on an occupied observation
MISS_DEC, 1, subtracted from a cell on a free observation
CELL_MAX, 2^(CELL_BITS-1)-1, upper saturation bound
CELL_MIN, -(2^(CELL_BITS-1)-1), lower saturation bound; the most-negative code is never produced

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
clear_req  in  1  one-cycle pulse; starts a clear sweep when the block is IDLE
busy  out  1  high while the clear sweep runs
clear_done  out  1  one-cycle pulse on the last clear write
upd_valid  in  1  update request valid
upd_ready  out  1  update request accepted when valid&ready
upd_x  in  X_BITS  update column
upd_y  in  Y_BITS  update row
upd_free  in  1  1 = free (apply -MISS_DEC), 0 = occupied (apply +HIT_INC)
qry_valid  in  1  query request
qry_ready  out  1  query accepted when valid&ready
qry_x  in  X_BITS  query column
qry_y  in  Y_BITS  query row
qry_data_valid  out  1  pulses one cycle after an accepted query
qry_data  out  CELL_BITS  signed cell value

Behaviour:
- Address = {y, x}; depth = 2^(X_BITS+Y_BITS). The RAM has synchronous read with 1-cycle latency; a read of the address being written in the same cycle returns OLD data.
- FSM states: CLEAR and IDLE.
  - Any cycle with reset_n=0 forces CLEAR with counter 0 and discards pipeline and query state.
  - Outputs while reset_n=0: busy=1, upd_ready=0, qry_ready=0, clear_done=0, qry_data_valid=0, qry_data=0.
  - On reset release the block stays in CLEAR, so an automatic sweep always follows reset.
- CLEAR:
  - Writes 0 to address = counter, one address per cycle, incrementing the counter.
  - busy=1, upd_ready=0, qry_ready=0.
  - On the write of address depth-1: clear_done=1 for that cycle; next state IDLE.
  - Sweep takes exactly depth cycles. The counter does not wrap into a second pass.
- IDLE:
  - upd_ready=1 and qry_ready=!upd_valid; updates have priority over queries.
  - clear_req in IDLE: moves to CLEAR next cycle, upd_ready drops that cycle, and any update in stage S1 still completes its write first.
  - clear_req while in CLEAR is ignored.
- Update pipeline:
  - S0 (accept cycle): issue RAM read of the address; register address and upd_free.
  - S1 (next cycle): old = RAM data, or the forwarded value (below).
  - new = saturating old+HIT_INC or old-MISS_DEC, computed at CELL_BITS+1 width and then clamped to [CELL_MIN, CELL_MAX]. Write new in S1.
- Forwarding: if the S0 address equals the S1 address of the write in progress, the next S1 uses the value written by the previous S1, not the RAM output. Back-to-back updates to the same cell therefore accumulate correctly (no lost updates).
- Query pipeline:
  - An accepted query issues a RAM read.
  - Next cycle: qry_data_valid=1 and qry_data = RAM data, with the same forwarding against an S1 write to that address.
  - qry_data holds its value until the next valid query.
- Simultaneous upd_valid and qry_valid: the update is accepted; the query stalls (qry_ready=0).

Decomposition:
- Package occupancy_pkg:
  - cell_t (signed [CELL_BITS-1:0]);
  - the state enum {CLEAR, IDLE};
  - a saturating add function sat_add(cell_t, signed delta, min, max).
- Sub-module grid_ram: parametrised ADDR_BITS/DATA_BITS simple-dual-port RAM with registered read and no reset. All FSM, forwarding and saturation logic stays in the top level.

Test Plan:
- Reset -> busy=1 for exactly 32768 cycles with defaults; clear_done pulses once, on the last; a query at (255,127) then returns 0.
- Update (3,5) occupied 3 times back-to-back -> query (3,5) returns 3 (forwarding exercised, no lost increments).
- Cell at 126, two occupied updates -> 127 then 127; cell at -126, two free updates -> -127 then -127 (never -128).
- upd_valid and qry_valid asserted together -> qry_ready=0 that cycle; query accepted the next cycle with the post-update value.
- Update in S1 when clear_req arrives -> the write completes, then the sweep zeroes that cell; queries during busy are refused.
- reset_n low mid-sweep at counter 1000 -> sweep restarts from address 0; clear_done occurs depth cycles after reset_n rises.
